// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_EX   = 2'd2
    } owner_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    // Wide enough for DATA_W up to 512; callers slice to DATA_W/8.
    localparam int                  MAX_BE_W = 64;
    localparam logic [MAX_BE_W-1:0] WE_FULL  = '1;

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Owner-tag shift register that follows a read through the memory latency.
module rd_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  owner_t tag_i,
    output owner_t tag_o
);

    owner_t tag_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= OWN_NONE;
        end else begin
            tag_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_o = tag_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single data-memory port shared by loader, fetch and execute; loader owns it
// until ldr_done, then execute has priority with a fetch starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4,
    parameter int MEM_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ldr_valid,
    input  logic [ADDR_W-1:0]   ldr_addr,
    input  logic [DATA_W-1:0]   ldr_wdata,
    output logic                ldr_ready,
    input  logic                ldr_done,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ex_req,
    input  logic [ADDR_W-1:0]   ex_addr,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W/8-1:0] ex_we,
    output logic                ex_gnt,
    output logic                ex_rvalid,
    output logic [DATA_W-1:0]   ex_rdata,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_we,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy_load
);

    localparam int              BE_W     = DATA_W / 8;
    localparam int              WC_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);

    arb_state_t        state_q, state_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic              cmd_en;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [BE_W-1:0]   cmd_we;
    owner_t            tag_d, tag_out;

    always_comb begin
        state_d   = state_q;
        ldr_ready = 1'b0;
        if_gnt    = 1'b0;
        ex_gnt    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                ldr_ready = ldr_valid;
                if (ldr_done) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ex_req && !(if_req && wait_q == WAIT_MAX)) ex_gnt = 1'b1;
                else if (if_req)                               if_gnt = 1'b1;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        wait_d = wait_q;
        if (!if_req || if_gnt)               wait_d = '0;
        else if (ex_gnt && wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
    end

    // Only one source can be active in a cycle, so the mux order is arbitrary.
    always_comb begin
        cmd_en    = ldr_ready | if_gnt | ex_gnt;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_we    = '0;
        tag_d     = OWN_NONE;
        if (ldr_ready) begin
            cmd_addr  = ldr_addr;
            cmd_wdata = ldr_wdata;
            cmd_we    = WE_FULL[BE_W-1:0];
        end else if (ex_gnt) begin
            cmd_addr  = ex_addr;
            cmd_wdata = ex_wdata;
            cmd_we    = ex_we;
            if (ex_we == '0) tag_d = OWN_EX;
        end else if (if_gnt) begin
            cmd_addr  = if_addr;
            tag_d     = OWN_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            wait_q    <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_en    <= cmd_en;
            mem_addr  <= cmd_addr;
            mem_wdata <= cmd_wdata;
            mem_we    <= cmd_we;
        end
    end

    rd_tag_pipe #(.DEPTH(MEM_LAT + 1)) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_d),
        .tag_o (tag_out)
    );

    assign if_rvalid = (tag_out == OWN_IF);
    assign ex_rvalid = (tag_out == OWN_EX);
    assign if_rdata  = mem_rdata;
    assign ex_rdata  = mem_rdata;
    assign busy_load = (state_q == ST_LOAD);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: load phase, starvation guard, read tagging, store, reset mid-flight.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              ldr_valid, ldr_ready, ldr_done;
    logic [ADDR_W-1:0] ldr_addr, if_addr, ex_addr, mem_addr;
    logic [DATA_W-1:0] ldr_wdata, ex_wdata, if_rdata, ex_rdata, mem_wdata, mem_rdata;
    logic              if_req, if_gnt, if_rvalid;
    logic              ex_req, ex_gnt, ex_rvalid;
    logic [7:0]        ex_we, mem_we;
    logic              mem_en, busy_load;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .ldr_valid(ldr_valid), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ready(ldr_ready), .ldr_done(ldr_done),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ex_req(ex_req), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_we(ex_we),
        .ex_gnt(ex_gnt), .ex_rvalid(ex_rvalid), .ex_rdata(ex_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy_load(busy_load)
    );

    // One-cycle memory: read data is a fixed pattern of the word address.
    always @(posedge clk) begin
        if (mem_en && mem_we == 8'h00)
            mem_rdata <= 64'hA5A5_0000_0000_0000 | 64'(mem_addr);
        else
            mem_rdata <= 64'h0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {if_gnt, ex_gnt}: EX=01, IF=10
    logic [1:0] exp_g [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                               2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    initial begin
        rst = 1'b1;
        ldr_valid = 0; ldr_addr = 0; ldr_wdata = 0; ldr_done = 0;
        if_req = 0; if_addr = 0;
        ex_req = 0; ex_addr = 0; ex_wdata = 0; ex_we = 0;
        step(); step();
        chk("rst_busy", busy_load, 1);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rvalid", {if_rvalid, ex_rvalid}, 0);

        // load phase; fetch requests throughout
        rst = 0;
        ldr_valid = 1; ldr_addr = 20'h10; ldr_wdata = 64'h1111_0000_0000_0010;
        if_req = 1; if_addr = 20'h30;
        #1;
        chk("ld0_ready", ldr_ready, 1);
        chk("ld0_if_gnt", if_gnt, 0);
        step();
        ldr_addr = 20'h11; ldr_wdata = 64'h1111_0000_0000_0011;
        #1;
        chk("ld1_ready", ldr_ready, 1);
        chk("ld1_if_gnt", if_gnt, 0);
        chk("ld1_mem_en", mem_en, 1);
        chk("ld1_mem_addr", mem_addr, 20'h10);
        chk("ld1_mem_we", mem_we, 8'hff);
        chk("ld1_mem_wdata", mem_wdata, 64'h1111_0000_0000_0010);
        step();
        ldr_addr = 20'h12; ldr_wdata = 64'h1111_0000_0000_0012; ldr_done = 1;
        #1;
        chk("ld2_ready", ldr_ready, 1);
        chk("ld2_if_gnt", if_gnt, 0);
        chk("ld2_busy", busy_load, 1);
        step();
        ldr_valid = 0; ldr_done = 0;
        #1;
        chk("run_busy", busy_load, 0);
        chk("run_ldr_ready", ldr_ready, 0);
        chk("ld_final_addr", mem_addr, 20'h12);
        chk("ld_final_we", mem_we, 8'hff);
        chk("ld_final_wdata", mem_wdata, 64'h1111_0000_0000_0012);
        chk("run_if_gnt", if_gnt, 1);
        step();

        // starvation guard, both requesting continuously
        ex_req = 1; ex_addr = 20'h40; ex_we = 8'h00;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("starve_gnt", {if_gnt, ex_gnt}, exp_g[k]);
            if (k == 1) begin
                chk("first_if_rvalid", if_rvalid, 1);
                chk("first_if_rdata", if_rdata, 64'hA5A5_0000_0000_0030);
            end
            step();
        end
        ex_req = 0; if_req = 0;
        step(); step(); step();

        // read-return tagging: EX read 0x20 then IF read 0x21
        ex_req = 1; ex_addr = 20'h20; ex_we = 8'h00;
        #1;
        chk("tag_ex_gnt", ex_gnt, 1);
        step();
        ex_req = 0; if_req = 1; if_addr = 20'h21;
        #1;
        chk("tag_if_gnt", if_gnt, 1);
        chk("tag_mem_addr", mem_addr, 20'h20);
        chk("tag_rv_t1", {if_rvalid, ex_rvalid}, 2'b00);
        step();
        if_req = 0;
        #1;
        chk("tag_ex_rv", {if_rvalid, ex_rvalid}, 2'b01);
        chk("tag_ex_rdata", ex_rdata, 64'hA5A5_0000_0000_0020);
        step();
        chk("tag_if_rv", {if_rvalid, ex_rvalid}, 2'b10);
        chk("tag_if_rdata", if_rdata, 64'hA5A5_0000_0000_0021);
        step();
        chk("tag_rv_idle", {if_rvalid, ex_rvalid}, 2'b00);

        // partial store
        ex_req = 1; ex_addr = 20'h22; ex_wdata = 64'hDEAD_BEEF_0000_0022; ex_we = 8'h0f;
        #1;
        chk("st_gnt", ex_gnt, 1);
        step();
        ex_req = 0; ex_we = 8'h00;
        #1;
        chk("st_mem_en", mem_en, 1);
        chk("st_mem_we", mem_we, 8'h0f);
        chk("st_mem_addr", mem_addr, 20'h22);
        chk("st_mem_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0022);
        step();
        chk("st_no_rv2", {if_rvalid, ex_rvalid}, 2'b00);
        step();
        chk("st_no_rv3", {if_rvalid, ex_rvalid}, 2'b00);

        // reset with a read in flight
        ex_req = 1; ex_addr = 20'h20; ex_we = 8'h00;
        #1;
        chk("rf_gnt", ex_gnt, 1);
        step();
        ex_req = 0; rst = 1;
        step();
        rst = 0;
        #1;
        chk("rf_no_rv", ex_rvalid, 0);
        chk("rf_busy", busy_load, 1);
        chk("rf_mem_en", mem_en, 0);
        step();
        chk("rf_no_rv_late", ex_rvalid, 0);
        chk("rf_busy_late", busy_load, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
